alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit registered ALU for the CPU execute stage.
- Performs add, subtract, bitwise AND or bitwise OR on operands A and B, selected by the 2-bit CTRL code.
- Registers the result together with the zero, signed-overflow and branch flags on the rising clock edge.
- The branch flag supports BEQ-style decisions: it asserts when a subtract finds equal operands.

Parameters:
- WIDTH, 32, operand and result width in bits. All behaviour below is stated for 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registered outputs immediately.
- A  input  32  operand A, two's complement.
- B  input  32  operand B, two's complement.
- CTRL  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- R  output  32  registered result.
- zero  output  1  registered; 1 when the registered R equals 0.
- ovf  output  1  registered signed-overflow flag.
- branch  output  1  registered; 1 when CTRL=01 and A equals B.

Behaviour:
- Reset: while reset=1, regardless of clk:
  - R=0, ovf=0, branch=0.
  - zero=1, consistent with R=0.
  - Releasing reset takes effect at the next rising edge; there are no further synchronisation requirements.
- Latency: one cycle. A, B and CTRL are sampled at rising edge N; R, zero, ovf and branch show that operation after edge N and hold until edge N+1.
  - No enable, no handshake: a new operation every cycle.
- Inputs are fully combinational into the output registers, and operations are independent cycle to cycle (no internal state).
- ADD (00): R = (A + B) mod 2^32.
  - ovf = 1 when A[31]==B[31] and R[31]!=A[31].
- SUB (01): R = (A - B) mod 2^32, implemented as A + ~B + 1.
  - ovf = 1 when A[31]!=B[31] and R[31]!=A[31].
- AND (10): R = A & B; ovf = 0.
- OR (11): R = A | B; ovf = 0.
- Carry-out is not reported.
- zero: computed from the next-state result and registered alongside R, so zero==(R==0) holds on every cycle, reset included.
- branch: registered, 1 only when CTRL=01 and the subtract result is 0 (A==B); 0 for every other op, even if R==0.
- Overflow wrap: R always holds the truncated 32-bit value; ovf only flags the condition and never saturates.
- X/unknown on inputs: no requirement. Reset mid-operation discards the in-flight result.

Test Plan:
- Reset: assert reset with A=5, B=7, CTRL=00 -> immediately R=0, zero=1, ovf=0, branch=0. Deassert, next edge -> R=12, zero=0.
- ADD overflow: A=32'h7FFFFFFF, B=1, CTRL=00 -> after one edge R=32'h80000000, ovf=1, zero=0. Then A=32'hFFFFFFFF, B=1 -> R=0, zero=1, ovf=0.
- SUB/branch: A=32'h12345678, B=32'h12345678, CTRL=01 -> R=0, zero=1, branch=1, ovf=0. Then B=32'h12345679 -> R=32'hFFFFFFFF, branch=0.
- SUB overflow: A=32'h80000000, B=1, CTRL=01 -> R=32'h7FFFFFFF, ovf=1.
- Logic ops: A=32'hF0F0F0F0, B=32'h0FF00FF0. CTRL=10 -> R=32'h00F000F0, ovf=0. CTRL=11 -> R=32'hFFF0FFF0. AND with B=32'h0F0F0F0F -> R=0, zero=1, branch=0.
- Random regression: 1000 cycles of random A, B, CTRL. The checker compares R/zero/ovf/branch one cycle later against a reference model; any mismatch fails.

Source files
------------

// File: rtl/alu.sv
// alu: registered 32-bit add/sub/and/or with zero, signed-overflow and branch flags
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       CTRL,
  output logic [WIDTH-1:0] R,
  output logic             zero,
  output logic             ovf,
  output logic             branch
);
  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] r_n;
  logic             ovf_n;
  always_comb begin
    sub   = CTRL == 2'b01;
    bx    = sub ? ~B : B;
    sum   = A + bx + {{(WIDTH-1){1'b0}}, sub};
    r_n   = CTRL[1] ? (CTRL[0] ? (A | B) : (A & B)) : sum;
    ovf_n = ~CTRL[1] & (A[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R      <= '0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
      branch <= 1'b0;
    end else begin
      R      <= r_n;
      zero   <= r_n == '0;
      ovf    <= ovf_n;
      branch <= sub & (r_n == '0);
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table plus randomized regression against a signed-arithmetic model
module tb_alu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [1:0]  CTRL;
  logic [31:0] R;
  logic        zero, ovf, branch;
  int          errors = 0;
  int          checks = 0;

  alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .CTRL(CTRL),
    .R(R), .zero(zero), .ovf(ovf), .branch(branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  c;
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        br;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        br;
  } res_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input res_t e);
    chk({tag, ".R"}, R, e.r);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, e.z});
    chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, e.o});
    chk({tag, ".branch"}, {31'b0, branch}, {31'b0, e.br});
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    A = a;
    B = b;
    CTRL = c;
    @(posedge clk);
    #1;
  endtask

  // Signed results are formed in 64 bits; overflow means the true value leaves the 32-bit signed range.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    res_t   m;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint full = 0;
    m.o = 1'b0;
    if (c == 2'd0) full = sa + sb;
    else if (c == 2'd1) full = sa - sb;
    if (c[1]) m.r = c[0] ? (a | b) : (a & b);
    else begin
      m.r = full[31:0];
      m.o = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    end
    m.z  = m.r == 32'd0;
    m.br = (c == 2'd1) && (a == b);
    return m;
  endfunction

  initial begin
    res_t e;
    logic [31:0] a, b;
    logic [1:0]  c;
    vt[0] = '{32'h7FFFFFFF, 32'h00000001, 2'b00, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h12345678, 32'h12345678, 2'b01, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[3] = '{32'h12345678, 32'h12345679, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[4] = '{32'h80000000, 32'h00000001, 2'b01, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vt[5] = '{32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'hF0F0F0F0, 32'h0FF00FF0, 2'b11, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 2'b10, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vt[8] = '{32'h80000000, 32'h80000000, 2'b00, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vt[9] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h80000000, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    A = 32'd5;
    B = 32'd7;
    CTRL = 2'b00;
    #2;
    chk_all("reset_hold", '{32'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("reset_release", '{32'd12, 1'b0, 1'b0, 1'b0});

    // Reset asserted between edges must clear the outputs without waiting for a clock.
    #2;
    reset = 1'b1;
    #1;
    chk_all("reset_async", '{32'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].a, vt[i].b, vt[i].c);
      chk_all($sformatf("vec%0d", i), '{vt[i].r, vt[i].z, vt[i].o, vt[i].br});
    end

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = 32'h80000000;
        2: b = 32'h7FFFFFFF;
        3: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      c = 2'($urandom_range(0, 3));
      e = model(a, b, c);
      cycle(a, b, c);
      chk_all($sformatf("rand%0d a=%h b=%h c=%0d", i, a, b, c), e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
